// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: request opcodes,
// FSM states and the default data_mem word-address width.
package mips_mem_pkg;

   localparam int DM_AW_DEF = 7;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LBU = 3'd1;
   localparam logic [2:0] OP_LH  = 3'd2;
   localparam logic [2:0] OP_LHU = 3'd3;
   localparam logic [2:0] OP_LW  = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   // IDLE accepts requests; RMW_WR writes back a merged sub-word store.
   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for a 32-bit word: extracts and extends
// byte/halfword load data, and merges sub-word store data into a word.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] rdata_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
   assign half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];

   // Load extraction: pick the addressed lane and sign/zero-extend it.
   always_comb begin
      load_data_o = rdata_i;
      case (op_i)
         OP_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data_o = {24'h000000, byte_sel};
         OP_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data_o = {16'h0000, half_sel};
         default: load_data_o = rdata_i;
      endcase
   end

   // Store merge: overwrite only the addressed lane of the current word.
   always_comb begin
      merged_o = rdata_i;
      if (op_i == OP_SB) begin
         merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end else if (op_i == OP_SH) begin
         merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide data memory.
// Handshake: a request is taken on any cycle where req_valid=1 and
// req_ready=1; when req_ready=0 the pipeline holds its request stable and
// the unit ignores it. Sub-word stores take a read cycle (accepted) plus a
// write-back cycle (stalled). Load results appear on wb_* one cycle later.
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int DM_AW = DM_AW_DEF,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [2:0]       req_op,
   input  logic [31:0]      req_addr,
   input  logic [DW-1:0]    req_wdata,
   input  logic [4:0]       req_rd,
   output logic             req_ready,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic [DW-1:0]    wb_data,
   output logic             exc_misalign,
   output logic [DM_AW-1:0] dm_addr,
   output logic             dm_wr,
   output logic             dm_rd,
   output logic [DW-1:0]    dm_wdata,
   input  logic [DW-1:0]    dm_rdata
);

   mau_state_e       state_q, state_d;
   logic [DM_AW-1:0] rmw_addr_q, rmw_addr_d;
   logic [DW-1:0]    rmw_data_q, rmw_data_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [DW-1:0]    wb_data_q, wb_data_d;
   logic             exc_q, exc_d;

   logic [DM_AW-1:0] word_addr;
   logic             out_of_range;
   logic             misalign;
   logic             is_load;
   logic [DW-1:0]    load_data;
   logic [DW-1:0]    merged_word;

   assign word_addr    = req_addr[DM_AW+1:2];
   assign out_of_range = |req_addr[31:DM_AW+2];
   assign is_load      = (req_op <= OP_LW);

   // Alignment check depends on the access size encoded in the opcode.
   always_comb begin
      misalign = 1'b0;
      case (req_op)
         OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
         OP_LW, OP_SW:         misalign = |req_addr[1:0];
         default:              misalign = 1'b0;
      endcase
   end

   mem_lane_align u_lane_align (
      .op_i        (req_op),
      .lane_i      (req_addr[1:0]),
      .rdata_i     (dm_rdata),
      .wdata_i     (req_wdata[15:0]),
      .load_data_o (load_data),
      .merged_o    (merged_word)
   );

   // Next-state and memory-side outputs; everything idles while in reset.
   always_comb begin
      state_d    = state_q;
      rmw_addr_d = rmw_addr_q;
      rmw_data_d = rmw_data_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      exc_d      = 1'b0;
      req_ready  = 1'b1;
      dm_addr    = '0;
      dm_wr      = 1'b0;
      dm_rd      = 1'b0;
      dm_wdata   = '0;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  if (misalign || out_of_range) begin
                     exc_d = 1'b1;
                  end else if (is_load) begin
                     dm_rd      = 1'b1;
                     dm_addr    = word_addr;
                     wb_valid_d = 1'b1;
                     wb_rd_d    = req_rd;
                     wb_data_d  = load_data;
                  end else if (req_op == OP_SW) begin
                     dm_wr    = 1'b1;
                     dm_addr  = word_addr;
                     dm_wdata = req_wdata;
                  end else begin
                     dm_rd      = 1'b1;
                     dm_addr    = word_addr;
                     rmw_addr_d = word_addr;
                     rmw_data_d = merged_word;
                     state_d    = RMW_WR;
                  end
               end
            end
            RMW_WR: begin
               req_ready = 1'b0;
               dm_wr     = 1'b1;
               dm_addr   = rmw_addr_q;
               dm_wdata  = rmw_data_q;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and result registers; reset abandons any pending write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rmw_addr_q <= '0;
         rmw_data_q <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         exc_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rmw_addr_q <= rmw_addr_d;
         rmw_data_q <= rmw_data_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         exc_q      <= exc_d;
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign exc_misalign = exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random checks for mem_access_unit against a byte-level
// reference model of memory and load/store semantics.
module tb_mem_access_unit;

   localparam int DM_AW = 7;
   localparam int NWORDS = 128;

   localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                          LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic [2:0]       req_op;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [4:0]       req_rd;
   logic             req_ready;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             exc_misalign;
   logic [DM_AW-1:0] dm_addr;
   logic             dm_wr;
   logic             dm_rd;
   logic [31:0]      dm_wdata;
   logic [31:0]      dm_rdata;

   logic [31:0] mem [0:NWORDS-1];
   logic [31:0] ref_mem [0:NWORDS-1];

   int total = 0;
   int bad   = 0;

   mem_access_unit #(.DM_AW(DM_AW), .DW(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .req_ready    (req_ready),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .exc_misalign (exc_misalign),
      .dm_addr      (dm_addr),
      .dm_wr        (dm_wr),
      .dm_rd        (dm_rd),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata)
   );

   // clock / data_mem model: combinational read, write at posedge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_rdata = mem[dm_addr];

   always @(posedge clk) begin
      if (dm_wr) mem[dm_addr] <= dm_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---- reference model ----
   function automatic bit ref_bad(input logic [2:0] op, input logic [31:0] addr);
      int unsigned a;
      a = addr;
      if (a >= NWORDS * 4) return 1'b1;
      if ((op == LH || op == LHU || op == SH) && (a % 2 != 0)) return 1'b1;
      if ((op == LW || op == SW) && (a % 4 != 0)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
      int unsigned sh;
      logic [31:0] w, b, h;
      w  = ref_mem[addr / 4];
      sh = (addr % 4) * 8;
      b  = (w >> sh) & 32'hFF;
      h  = (w >> sh) & 32'hFFFF;
      case (op)
         LB:      return (b > 127) ? (b + 32'hFFFFFF00) : b;
         LBU:     return b;
         LH:      return (h > 32767) ? (h + 32'hFFFF0000) : h;
         LHU:     return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] wd);
      int unsigned sh;
      logic [31:0] w, mask;
      w  = ref_mem[addr / 4];
      sh = (addr % 4) * 8;
      if (op == SB) begin
         mask = 32'hFF << sh;
         return (w & ~mask) | ((wd & 32'hFF) << sh);
      end else if (op == SH) begin
         mask = 32'hFFFF << sh;
         return (w & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      return wd;
   endfunction

   // ---- driver tasks ----
   // One request, driven at negedge; sub-word stores also cover the stall cycle.
   task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
      bit          err, ld;
      logic [31:0] exp_ld, exp_st;
      err = ref_bad(op, addr);
      ld  = (op <= LW);
      exp_ld = err ? 32'h0 : ref_load(op, addr);
      exp_st = err ? 32'h0 : ref_store(op, addr, wd);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
      #1;
      chk("req_ready", {31'b0, req_ready}, 32'd1);
      if (err) begin
         chk("err_dm_wr", {31'b0, dm_wr}, 32'd0);
         chk("err_dm_rd", {31'b0, dm_rd}, 32'd0);
      end else if (op == SW) begin
         chk("sw_dm_wr", {31'b0, dm_wr}, 32'd1);
         chk("sw_dm_addr", {25'b0, dm_addr}, addr / 4);
         chk("sw_dm_wdata", dm_wdata, wd);
      end else begin
         chk("rd_dm_rd", {31'b0, dm_rd}, 32'd1);
         chk("rd_dm_wr", {31'b0, dm_wr}, 32'd0);
         chk("rd_dm_addr", {25'b0, dm_addr}, addr / 4);
      end
      @(posedge clk); #1;
      chk("exc_misalign", {31'b0, exc_misalign}, {31'b0, err});
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, (ld && !err)});
      if (ld && !err) begin
         chk("wb_data", wb_data, exp_ld);
         chk("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
      end
      if (!err && !ld) ref_mem[addr / 4] = exp_st;
      if (!err && (op == SB || op == SH)) begin
         chk("rmw_ready", {31'b0, req_ready}, 32'd0);
         chk("rmw_dm_wr", {31'b0, dm_wr}, 32'd1);
         chk("rmw_dm_addr", {25'b0, dm_addr}, addr / 4);
         chk("rmw_dm_wdata", dm_wdata, exp_st);
         @(posedge clk); #1;
         chk("rmw_wb_valid", {31'b0, wb_valid}, 32'd0);
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      req_valid = 1'b0; req_op = LW; req_addr = 32'h0000_0124; req_wdata = 32'hFFFF_FFFF;
      #1;
      chk("idle_dm_wr", {31'b0, dm_wr}, 32'd0);
      chk("idle_dm_rd", {31'b0, dm_rd}, 32'd0);
      chk("idle_dm_addr", {25'b0, dm_addr}, 32'd0);
      chk("idle_dm_wdata", dm_wdata, 32'd0);
      @(posedge clk); #1;
      chk("idle_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("idle_exc", {31'b0, exc_misalign}, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
      chk({tag, "_dm_wr"}, {31'b0, dm_wr}, 32'd0);
      chk({tag, "_dm_rd"}, {31'b0, dm_rd}, 32'd0);
      chk({tag, "_dm_addr"}, {25'b0, dm_addr}, 32'd0);
      chk({tag, "_dm_wdata"}, dm_wdata, 32'd0);
      chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
      chk({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd0);
      chk({tag, "_wb_data"}, wb_data, 32'd0);
      chk({tag, "_exc"}, {31'b0, exc_misalign}, 32'd0);
   endtask

   // ---- directed + random sequence ----
   initial begin
      logic [31:0] waddrs [0:15];
      logic [31:0] a;

      for (int i = 0; i < NWORDS; i++) begin
         mem[i]     = (i == 9) ? 32'h0 : $urandom;
         ref_mem[i] = mem[i];
      end
      rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
      req_wdata = 32'h0; req_rd = 5'd0;
      #12;
      chk_reset_outputs("rst");
      @(negedge clk); rst_n = 1'b1;

      // store then back-to-back load of the same word
      do_op(SW, 32'h24, 32'hDEADBEEF, 5'd3);
      do_op(LW, 32'h24, 32'h0, 5'd7);
      idle_cycle();

      // sub-word loads with sign/zero extension
      do_op(LB,  32'h25, 32'h0, 5'd1);
      chk("lb_const", wb_data, 32'hFFFFFFBE);
      do_op(LBU, 32'h25, 32'h0, 5'd2);
      chk("lbu_const", wb_data, 32'h000000BE);
      do_op(LH,  32'h26, 32'h0, 5'd4);
      chk("lh_const", wb_data, 32'hFFFFDEAD);
      do_op(LHU, 32'h26, 32'h0, 5'd5);
      chk("lhu_const", wb_data, 32'h0000DEAD);

      // read-modify-write stores
      do_op(SB, 32'h27, 32'hFFFFFF11, 5'd0);
      do_op(LW, 32'h24, 32'h0, 5'd6);
      chk("sb_const", wb_data, 32'h11ADBEEF);
      do_op(SH, 32'h24, 32'hABCD5566, 5'd0);
      do_op(LW, 32'h24, 32'h0, 5'd8);
      chk("sh_const", wb_data, 32'h11AD5566);

      // dropped accesses
      do_op(LW, 32'h26, 32'h0, 5'd9);
      do_op(SH, 32'h25, 32'h7777, 5'd0);
      do_op(LW, 32'h200, 32'h0, 5'd10);
      do_op(SW, 32'h8000_0024, 32'h1234_5678, 5'd0);
      do_op(LW, 32'h24, 32'h0, 5'd11);
      chk("err_mem_kept", wb_data, 32'h11AD5566);

      // reset while the RMW write-back is pending
      do_op(LB, 32'h24, 32'h0, 5'd12);
      @(negedge clk);
      req_valid = 1'b1; req_op = SB; req_addr = 32'h24; req_wdata = 32'hAA; req_rd = 5'd0;
      @(posedge clk); #1;
      chk("pre_rst_ready", {31'b0, req_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rmw_rst");
      @(posedge clk); #1;
      chk_reset_outputs("rmw_rst_hold");
      @(negedge clk); rst_n = 1'b1; req_valid = 1'b0;
      do_op(LW, 32'h24, 32'h0, 5'd13);
      chk("rst_mem_kept", wb_data, 32'h11AD5566);

      // random SW/LW traffic over 16 word addresses, no idle cycles
      for (int i = 0; i < 16; i++) waddrs[i] = $urandom_range(0, NWORDS - 1) * 4;
      for (int i = 0; i < 60; i++) begin
         a = waddrs[$urandom_range(0, 15)];
         do_op(SW, a, $urandom, 5'($urandom_range(0, 31)));
         a = waddrs[$urandom_range(0, 15)];
         do_op(LW, a, 32'h0, 5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 30; i++) begin
         a = waddrs[$urandom_range(0, 15)] + 32'($urandom_range(0, 3));
         do_op(3'($urandom_range(0, 7)), a, $urandom, 5'($urandom_range(0, 31)));
      end
      for (int i = 0; i < 16; i++) do_op(LW, waddrs[i], 32'h0, 5'(i));
      idle_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
